spike_event_arbiter: RTL and testbench

Serializes the parallel `spike` vector of a `lif_array` into a single address-event (AER) stream. Each spike is captured in a per-neuron pending slot with a timestamp. Pending events are granted round-robin onto one valid/ready output port, and spikes that cannot be buffered are counted as drops. The block sits between the neuron array and any downstream event consumer: router, logger or synapse engine.

---
 rtl/snn_pkg.sv | 29 ++
 rtl/rr_pick.sv | 27 ++
 rtl/spike_event_arbiter.sv | 157 +++++++++++++++
 tb/tb_spike_event_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for spiking-network event blocks: width helper,
// drop counter width, output-stage states and the AER event record.
package snn_pkg;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int DROP_W     = 8;
  localparam int AER_N      = 4;
  localparam int AER_ADDR_W = clog2_min1(AER_N);
  localparam int AER_TS_W   = 16;

  typedef struct packed {
    logic [AER_ADDR_W-1:0] addr;
    logic [AER_TS_W-1:0]   ts;
  } aer_event_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first request strictly
// after last_i, wrapping at N.
module rr_pick #(
  parameter int N      = 4,
  parameter int ADDR_W = 2
) (
  input  logic [N-1:0]      req_i,
  input  logic [ADDR_W-1:0] last_i,
  output logic [ADDR_W-1:0] gnt_o,
  output logic              any_o
);

  logic [ADDR_W-1:0] idx_s;

  // Scan farthest-to-nearest so the request closest after last_i wins
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx_s = '0;
    for (int k = N; k >= 1; k--) begin
      idx_s = ADDR_W'((int'(last_i) + k) % N);
      gnt_o = req_i[idx_s] ? idx_s : gnt_o;
      any_o = req_i[idx_s] | any_o;
    end
  end

endmodule

// File: rtl/spike_event_arbiter.sv
// Captures parallel spikes into timestamped pending slots and serialises
// them round-robin onto a single valid/ready AER port, counting drops.
module spike_event_arbiter
  import snn_pkg::*;
#(
  parameter int N      = 4,
  parameter int ADDR_W = clog2_min1(N),
  parameter int TS_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N-1:0]      spike_in,
  output logic              aer_valid,
  input  logic              aer_ready,
  output logic [ADDR_W-1:0] aer_addr,
  output logic [TS_W-1:0]   aer_ts,
  output logic [N-1:0]      pending,
  output logic [DROP_W-1:0] drop_count,
  input  logic              clear_drops
);

  out_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TS_W-1:0]   ts_out_q, ts_out_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [TS_W-1:0]   ts_now_q, ts_now_d;
  logic [N-1:0]      pend_q, pend_d;
  logic [TS_W-1:0]   slot_q [N];
  logic [TS_W-1:0]   slot_d [N];
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [ADDR_W-1:0] gnt_s;
  logic              any_s;
  logic              load_s;
  logic [N-1:0]      drop_vec_s;
  logic [DROP_W:0]   drop_inc_s;
  logic [DROP_W:0]   drop_sum_s;

  rr_pick #(.N(N), .ADDR_W(ADDR_W)) u_pick (
    .req_i  (pend_q),
    .last_i (last_q),
    .gnt_o  (gnt_s),
    .any_o  (any_s)
  );

  assign load_s   = any_s & ((state_q == OUT_EMPTY) | aer_ready);
  assign ts_now_d = enable ? (ts_now_q + TS_W'(1)) : ts_now_q;

  // Slot update: the granted slot frees first, so a same-cycle spike refills it
  always_comb begin
    pend_d     = pend_q;
    slot_d     = slot_q;
    drop_vec_s = '0;
    for (int i = 0; i < N; i++) begin
      if (load_s && (gnt_s == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = pend_q[i];
      end
      if (enable && spike_in[i]) begin
        if (!pend_d[i]) begin
          pend_d[i] = 1'b1;
          slot_d[i] = ts_now_q;
        end else begin
          drop_vec_s[i] = 1'b1;
        end
      end else begin
        drop_vec_s[i] = 1'b0;
      end
    end
  end

  // Saturating drop counter; a clear wins over same-cycle drops
  always_comb begin
    drop_inc_s = '0;
    for (int i = 0; i < N; i++) begin
      drop_inc_s = drop_inc_s + (DROP_W+1)'(drop_vec_s[i]);
    end
    drop_sum_s = {1'b0, drop_q} + drop_inc_s;
    if (clear_drops) begin
      drop_d = '0;
    end else if (drop_sum_s[DROP_W]) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum_s[DROP_W-1:0];
    end
  end

  // Output stage next state and payload load
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ts_out_d = ts_out_q;
    last_d   = last_q;
    case (state_q)
      OUT_EMPTY: begin
        if (load_s) begin
          state_d = OUT_FULL;
        end else begin
          state_d = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (aer_ready && !any_s) begin
          state_d = OUT_EMPTY;
        end else begin
          state_d = OUT_FULL;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    if (load_s) begin
      addr_d   = gnt_s;
      ts_out_d = slot_q[gnt_s];
      last_d   = gnt_s;
    end else begin
      addr_d   = addr_q;
      ts_out_d = ts_out_q;
      last_d   = last_q;
    end
  end

  // State registers; last grant resets to N-1 so the first search starts at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OUT_EMPTY;
      addr_q   <= '0;
      ts_out_q <= '0;
      last_q   <= ADDR_W'(N - 1);
      ts_now_q <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ts_out_q <= ts_out_d;
      last_q   <= last_d;
      ts_now_q <= ts_now_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign aer_valid  = (state_q == OUT_FULL);
  assign aer_addr   = addr_q;
  assign aer_ts     = ts_out_q;
  assign pending    = pend_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed and randomized bench for spike_event_arbiter, checked against an
// event-level reference model of slots, round-robin grants and drops.
module tb_spike_event_arbiter;

  localparam int N      = 4;
  localparam int ADDR_W = 2;
  localparam int TS_W   = 16;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [N-1:0]      spike_in;
  logic              aer_valid;
  logic              aer_ready;
  logic [ADDR_W-1:0] aer_addr;
  logic [TS_W-1:0]   aer_ts;
  logic [N-1:0]      pending;
  logic [7:0]        drop_count;
  logic              clear_drops;

  int checks;
  int errors;

  int unsigned m_ts_now;
  bit [N-1:0]  m_pend;
  int unsigned m_slot [N];
  int          m_last;
  bit          m_full;
  int          m_addr;
  int unsigned m_ts_out;
  int          m_drop;

  spike_event_arbiter #(.N(N), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spike_in    (spike_in),
    .aer_valid   (aer_valid),
    .aer_ready   (aer_ready),
    .aer_addr    (aer_addr),
    .aer_ts      (aer_ts),
    .pending     (pending),
    .drop_count  (drop_count),
    .clear_drops (clear_drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ts_now = 0;
    m_pend   = '0;
    for (int i = 0; i < N; i++) m_slot[i] = 0;
    m_last   = N - 1;
    m_full   = 1'b0;
    m_addr   = 0;
    m_ts_out = 0;
    m_drop   = 0;
  endtask

  // One clock edge of the event-level behaviour, using the current inputs
  task automatic model_step();
    int g;
    int nd;
    bit load;
    bit [N-1:0] np;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
    end
    load = (g >= 0) && (!m_full || aer_ready);
    np = m_pend;
    nd = 0;
    if (load) begin
      np[g]    = 1'b0;
      m_addr   = g;
      m_ts_out = m_slot[g];
      m_last   = g;
      m_full   = 1'b1;
    end else if (m_full && aer_ready) begin
      m_full = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (enable && spike_in[i]) begin
        if (!m_pend[i] || (load && g == i)) begin
          np[i]     = 1'b1;
          m_slot[i] = m_ts_now;
        end else begin
          nd++;
        end
      end
    end
    m_pend = np;
    if (clear_drops) m_drop = 0;
    else m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    if (enable) m_ts_now = (m_ts_now + 1) % (1 << TS_W);
  endtask

  task automatic check_all();
    chk("valid", 32'(aer_valid), 32'(m_full));
    if (m_full) begin
      chk("addr", 32'(aer_addr), 32'(m_addr));
      chk("ts", 32'(aer_ts), m_ts_out);
    end
    chk("pending", 32'(pending), 32'(m_pend));
    chk("drops", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    chk("rst_valid", 32'(aer_valid), 32'd0);
    chk("rst_addr", 32'(aer_addr), 32'd0);
    chk("rst_ts", 32'(aer_ts), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    enable = 1'b0;
    spike_in = '0;
    aer_ready = 1'b1;
    clear_drops = 1'b0;
    model_reset();

    // Single spike on neuron 2 captured with ts_now = 3
    do_reset();
    enable = 1'b1;
    repeat (3) step();
    spike_in = 4'b0100;
    step();
    spike_in = 4'b0000;
    step();
    chk("single_valid", 32'(aer_valid), 32'd1);
    chk("single_addr", 32'(aer_addr), 32'd2);
    chk("single_ts", 32'(aer_ts), 32'd3);
    step();
    chk("single_once", 32'(aer_valid), 32'd0);

    // Burst of all four neurons at ts_now = 5
    do_reset();
    repeat (5) step();
    spike_in = 4'b1111;
    step();
    spike_in = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("burst_valid", 32'(aer_valid), 32'd1);
      chk("burst_addr", 32'(aer_addr), 32'(j));
      chk("burst_ts", 32'(aer_ts), 32'd5);
    end
    chk("burst_drops", 32'(drop_count), 32'd0);
    step();

    // Fairness: neurons 0 and 3 spiking every cycle alternate on the output
    do_reset();
    spike_in = 4'b1001;
    step();
    for (int j = 0; j < 6; j++) begin
      step();
      chk("fair_addr", 32'(aer_addr), (j % 2 == 0) ? 32'd0 : 32'd3);
    end
    spike_in = 4'b0000;
    repeat (3) step();

    // Backpressure: six spikes on neuron 1 while stalled
    do_reset();
    aer_ready = 1'b0;
    spike_in = 4'b0010;
    for (int j = 0; j < 6; j++) begin
      step();
      if (j >= 1) begin
        chk("bp_addr", 32'(aer_addr), 32'd1);
        chk("bp_ts", 32'(aer_ts), 32'd0);
      end
    end
    chk("bp_drops", 32'(drop_count), 32'd4);
    chk("bp_pending", 32'(pending), 32'd2);
    spike_in = 4'b0000;
    aer_ready = 1'b1;
    repeat (3) step();

    // Saturation of the drop counter, then clear with drops in the same cycle
    do_reset();
    aer_ready = 1'b0;
    spike_in = 4'b1111;
    repeat (80) step();
    chk("sat_drops", 32'(drop_count), 32'd255);
    clear_drops = 1'b1;
    step();
    chk("clear_drops", 32'(drop_count), 32'd0);
    clear_drops = 1'b0;
    step();
    spike_in = 4'b0000;
    aer_ready = 1'b1;
    repeat (6) step();

    // Asynchronous reset while FULL with pending 1010
    do_reset();
    aer_ready = 1'b0;
    spike_in = 4'b0001;
    step();
    spike_in = 4'b1010;
    step();
    chk("mid_full", 32'(aer_valid), 32'd1);
    chk("mid_pending", 32'(pending), 32'd10);
    spike_in = 4'b0000;
    do_reset();
    aer_ready = 1'b1;
    spike_in = 4'b1000;
    step();
    spike_in = 4'b0000;
    step();
    chk("post_rst_addr", 32'(aer_addr), 32'd3);
    chk("post_rst_ts", 32'(aer_ts), 32'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      enable      = ($urandom_range(0, 7) != 0);
      spike_in    = N'($urandom);
      aer_ready   = ($urandom_range(0, 3) != 0);
      clear_drops = ($urandom_range(0, 31) == 0);
      step();
      if (c == 200) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
